// File: rtl/mmio_pkg.sv
// Shared register-map constants for the MMIO port responder.
// Offsets are word indices (Address[4:2]); bit indices locate STATUS/CTRL fields.
package mmio_pkg;

  localparam logic [2:0] OFF_PORT_OUT  = 3'd0;
  localparam logic [2:0] OFF_PORT_IN   = 3'd1;
  localparam logic [2:0] OFF_FIFO_DATA = 3'd2;
  localparam logic [2:0] OFF_STATUS    = 3'd3;
  localparam logic [2:0] OFF_CTRL      = 3'd4;

  localparam int STATUS_OVF_BIT  = 9;
  localparam int STATUS_FULL_BIT = 8;
  localparam int CTRL_CAP_EN_BIT = 0;
  localparam int CTRL_CLR_BIT    = 1;

  function automatic logic [31:0] status_word(
    input logic       ovf,
    input logic       full,
    input logic [7:0] count
  );
    return {22'b0, ovf, full, count};
  endfunction

endpackage

// File: rtl/mmio_sync_fifo.sv
// Synchronous capture FIFO with clear, show-ahead output and overflow pulse.
// Ports: clk, reset, clr, push/din, pop/dout, count, full, empty, ovf_pulse.
module mmio_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             ovf_pulse
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts
  // a simultaneous push. Clear overrides both and suppresses overflow.
  always_comb begin
    do_pop    = pop && !empty && !clr;
    do_push   = push && (!full || do_pop) && !clr;
    ovf_pulse = push && full && !do_pop && !clr;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_port_responder.sv
// MEM-stage MMIO responder: PortOut register, synchronized PortIn, change-capture FIFO.
// Ports: clk, reset, Address/WriteData/MemWrite/MemRead, ReadData, Hit, PortIn, PortOut, InPending.
module mmio_port_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0100,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        InPending
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
  logic [7:0]  prev_q;
  logic [7:0]  sync_out;
  logic [31:0] port_out_q, port_out_d;
  logic        cap_en_q, cap_en_d;
  logic        ovf_q, ovf_d;

  logic [2:0]    off;
  logic          rd, wr;
  logic          push, pop, clr;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          full, empty, ovf_pulse;
  logic          unused_addr;

  assign unused_addr = ^Address[1:0];

  assign Hit       = (Address[31:5] == BASE_ADDR[31:5]);
  assign off       = Address[4:2];
  assign rd        = MemRead && Hit;
  assign wr        = MemWrite && Hit;
  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign PortOut   = port_out_q;
  assign InPending = !empty;

  assign push = cap_en_q && (sync_out != prev_q);
  assign pop  = rd && (off == OFF_FIFO_DATA);
  assign clr  = wr && (off == OFF_CTRL) && WriteData[CTRL_CLR_BIT];

  mmio_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .push      (push),
    .din       (sync_out),
    .pop       (pop),
    .dout      (head),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ovf_pulse (ovf_pulse)
  );

  // Read mux reflects pre-edge state, so a same-cycle write is not visible.
  always_comb begin
    ReadData = '0;
    if (rd) begin
      case (off)
        OFF_PORT_OUT:  ReadData = port_out_q;
        OFF_PORT_IN:   ReadData = {24'b0, sync_out};
        OFF_FIFO_DATA: ReadData = empty ? 32'b0 : {24'b0, head};
        OFF_STATUS:    ReadData = status_word(ovf_q, full, 8'(count));
        OFF_CTRL:      ReadData = {31'b0, cap_en_q};
        default:       ReadData = '0;
      endcase
    end
  end

  // A fresh overflow in the same cycle as a W1C keeps ovf set.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], PortIn};
    port_out_d = port_out_q;
    cap_en_d   = cap_en_q;
    ovf_d      = ovf_q;
    if (wr && off == OFF_PORT_OUT) port_out_d = WriteData;
    if (wr && off == OFF_CTRL)     cap_en_d   = WriteData[CTRL_CAP_EN_BIT];
    if (wr && off == OFF_STATUS && WriteData[STATUS_OVF_BIT]) ovf_d = 1'b0;
    if (ovf_pulse) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      prev_q     <= '0;
      port_out_q <= '0;
      cap_en_q   <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= sync_out;
      port_out_q <= port_out_d;
      cap_en_q   <= cap_en_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Randomized bench for mmio_port_responder against a queue-based reference model.
// Directed register-map scenarios first, then constrained-random bus/PortIn traffic.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE  = 32'h1001_0100;
  localparam int          DEPTH = 8;
  localparam int          SYNC  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, WriteData;
  logic        MemWrite, MemRead;
  logic [31:0] ReadData;
  logic        Hit;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        InPending;

  always #5 clk = ~clk;

  mmio_port_responder #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ReadData  (ReadData),
    .Hit       (Hit),
    .PortIn    (PortIn),
    .PortOut   (PortOut),
    .InPending (InPending)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the input path is a plain delay line of SYNC samples,
  // the FIFO is a bounded queue.
  logic [31:0] m_port_out;
  logic        m_cap_en;
  logic        m_ovf;
  logic [7:0]  m_delay [SYNC];
  logic [7:0]  m_prev;
  logic [7:0]  m_q [$];

  logic [31:0] rd_seen;
  logic        hit_seen;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [2:0] o;
    logic [7:0] cnt;
    o   = a[4:2];
    cnt = 8'(m_q.size());
    if (a[31:5] != BASE[31:5]) return 32'b0;
    case (o)
      3'd0: return m_port_out;
      3'd1: return {24'b0, m_delay[SYNC-1]};
      3'd2: return (m_q.size() > 0) ? {24'b0, m_q[0]} : 32'b0;
      3'd3: return {22'b0, m_ovf, (m_q.size() == DEPTH), cnt};
      3'd4: return {31'b0, m_cap_en};
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_edge(input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [7:0] pin, input logic rst);
    logic       in_win;
    logic [7:0] s_out;
    logic       chg;
    if (rst) begin
      m_port_out = 0;
      m_cap_en   = 1;
      m_ovf      = 0;
      m_prev     = 0;
      for (int i = 0; i < SYNC; i++) m_delay[i] = 0;
      m_q.delete();
      return;
    end
    in_win = (a[31:5] == BASE[31:5]);
    s_out  = m_delay[SYNC-1];
    chg    = m_cap_en && (s_out != m_prev);
    if (in_win && wr && a[4:2] == 3'd3 && wd[9]) m_ovf = 0;
    if (in_win && wr && a[4:2] == 3'd4 && wd[1]) begin
      m_q.delete();
    end else begin
      if (in_win && rd && a[4:2] == 3'd2 && m_q.size() > 0)
        void'(m_q.pop_front());
      if (chg) begin
        if (m_q.size() < DEPTH) m_q.push_back(s_out);
        else m_ovf = 1;
      end
    end
    if (in_win && wr && a[4:2] == 3'd0) m_port_out = wd;
    if (in_win && wr && a[4:2] == 3'd4) m_cap_en = wd[0];
    for (int i = SYNC - 1; i > 0; i--) m_delay[i] = m_delay[i-1];
    m_delay[0] = pin;
    m_prev     = s_out;
  endtask

  // One bus cycle: drive, compare combinational and registered outputs,
  // then advance the model across the rising edge.
  task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [7:0] pin,
                      input logic rst);
    logic [31:0] exp_rd;
    MemRead   = rd;
    MemWrite  = wr;
    Address   = a;
    WriteData = wd;
    PortIn    = pin;
    reset     = rst;
    #1;
    exp_rd = rd ? model_read(a) : 32'b0;
    if (!rst) begin
      check("hit", {31'b0, Hit}, {31'b0, (a[31:5] == BASE[31:5])});
      check("read_data", ReadData, exp_rd);
      check("port_out", PortOut, m_port_out);
      check("in_pending", {31'b0, InPending}, {31'b0, (m_q.size() != 0)});
    end
    rd_seen  = ReadData;
    hit_seen = Hit;
    @(posedge clk);
    model_edge(rd, wr, a, wd, pin, rst);
    #1;
  endtask

  task automatic idle(input logic [7:0] pin);
    step(1'b0, 1'b0, 32'h0, 32'h0, pin, 1'b0);
  endtask

  task automatic rd_reg(input logic [4:0] o, input logic [7:0] pin);
    step(1'b1, 1'b0, BASE + 32'(o), 32'h0, pin, 1'b0);
  endtask

  task automatic wr_reg(input logic [4:0] o, input logic [31:0] d,
                        input logic [7:0] pin);
    step(1'b0, 1'b1, BASE + 32'(o), d, pin, 1'b0);
  endtask

  logic [7:0]  pin_r;
  logic [31:0] a_r, d_r;
  logic        r_r, w_r, rst_r;

  initial begin
    MemRead = 0; MemWrite = 0; Address = 0; WriteData = 0;
    PortIn = 0; reset = 1;
    @(posedge clk); #1;
    step(1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 1'b1);

    // Reset values.
    rd_reg(5'h00, 8'h00); check("rst_port_out", rd_seen, 32'h0);
    rd_reg(5'h0C, 8'h00); check("rst_status", rd_seen, 32'h0);
    rd_reg(5'h10, 8'h00); check("rst_ctrl", rd_seen, 32'h1);
    check("rst_pending", {31'b0, InPending}, 32'h0);

    // PortOut store/load and window edge.
    wr_reg(5'h00, 32'hDEAD_BEEF, 8'h00);
    check("port_out_reg", PortOut, 32'hDEAD_BEEF);
    rd_reg(5'h00, 8'h00); check("port_out_load", rd_seen, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, BASE + 32'h20, 32'h0, 8'h00, 1'b0);
    check("hit_outside", {31'b0, hit_seen}, 32'h0);
    check("read_outside", rd_seen, 32'h0);

    // Capture latency.
    idle(8'h5A);
    idle(8'h5A);
    rd_reg(5'h04, 8'h5A); check("port_in_lat", rd_seen, 32'h5A);
    rd_reg(5'h0C, 8'h5A); check("count_one", rd_seen, 32'h1);
    rd_reg(5'h08, 8'h5A); check("fifo_pop", rd_seen, 32'h5A);
    rd_reg(5'h0C, 8'h5A); check("count_zero", rd_seen, 32'h0);

    // Nine changes overflow an 8-deep FIFO.
    for (int i = 1; i <= 9; i++) idle(8'(i));
    for (int i = 0; i <= SYNC; i++) idle(8'h09);
    rd_reg(5'h0C, 8'h09); check("full_ovf", rd_seen, 32'h0000_0308);
    for (int i = 1; i <= 8; i++) begin
      rd_reg(5'h08, 8'h09); check("drain_order", rd_seen, 32'(i));
    end
    rd_reg(5'h08, 8'h09); check("read_empty", rd_seen, 32'h0);

    // Refill to full, then pop and push in the same cycle.
    for (int i = 0; i < 8; i++) idle(8'(8'h20 + i));
    for (int i = 0; i < SYNC - 1; i++) idle(8'h27);
    idle(8'h28);
    idle(8'h28);
    rd_reg(5'h08, 8'h28); check("pop_full", rd_seen, 32'h20);
    rd_reg(5'h0C, 8'h28); check("full_kept", rd_seen, 32'h0000_0308);
    wr_reg(5'h0C, 32'h200, 8'h28);
    rd_reg(5'h0C, 8'h28); check("ovf_w1c", rd_seen, 32'h0000_0108);

    // Capture disable, then clear with cap re-enable.
    wr_reg(5'h10, 32'h0, 8'h28);
    idle(8'h33); idle(8'h44); idle(8'h44); idle(8'h44);
    rd_reg(5'h0C, 8'h44); check("cap_off", rd_seen, 32'h0000_0108);
    wr_reg(5'h10, 32'h3, 8'h55);
    rd_reg(5'h0C, 8'h55); check("clr_count", rd_seen, 32'h0);
    rd_reg(5'h10, 8'h55); check("clr_ctrl", rd_seen, 32'h1);

    // Constrained-random traffic with occasional mid-stream reset.
    pin_r = 8'h55;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) < 4) pin_r = 8'($urandom);
      a_r = BASE + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) a_r = $urandom;
      r_r = ($urandom_range(0, 9) < 4);
      w_r = ($urandom_range(0, 9) < 2);
      d_r = $urandom;
      if (a_r[4:2] == 3'd4) begin
        d_r[0] = ($urandom_range(0, 9) < 8);
        d_r[1] = ($urandom_range(0, 29) == 0);
      end
      rst_r = ($urandom_range(0, 499) == 0);
      step(r_r, w_r, a_r, d_r, pin_r, rst_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
